// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs, round-robin grant onto registered CDB lanes.
// Optional macro CDB_BYPASS_EN lets a result entering an empty FIFO win a lane in the same cycle.
module cdb_arbiter #(
    parameter int N_SRC        = 4,
    parameter int CDB_SIZE     = 3,
    parameter int ROB_DEPTH    = 4,
    parameter int Q_DEPTH_BITS = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                move_flush,
    input  logic [N_SRC-1:0]                    fu_valid,
    output logic [N_SRC-1:0]                    fu_ready,
    input  logic [N_SRC-1:0][ROB_DEPTH-1:0]     fu_rob,
    input  logic [N_SRC-1:0][31:0]              fu_rd_v,
    output logic [CDB_SIZE-1:0]                 cdb_valid,
    output logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]  cdb_rob,
    output logic [CDB_SIZE-1:0][31:0]           cdb_rd_v
);

    localparam int QD = 2 ** Q_DEPTH_BITS;
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int EW = ROB_DEPTH + 32;
    localparam logic [Q_DEPTH_BITS:0] FULL = (Q_DEPTH_BITS + 1)'(QD);

    typedef logic [EW-1:0] ent_t;

    ent_t                    mem [N_SRC][QD];
    logic [Q_DEPTH_BITS-1:0] head [N_SRC];
    logic [Q_DEPTH_BITS-1:0] tail [N_SRC];
    logic [Q_DEPTH_BITS:0]   cnt  [N_SRC];
    logic [SW-1:0]           rr_ptr;

    logic                    flush;
    logic [N_SRC-1:0]        push;
    logic [N_SRC-1:0]        nonempty;
    logic [N_SRC-1:0]        elig;
    logic [N_SRC-1:0]        gnt;
    logic [N_SRC-1:0]        pop;
    logic [N_SRC-1:0]        wr;
    ent_t                    src_ent [N_SRC];

    logic [CDB_SIZE-1:0]     lane_vld;
    logic [SW-1:0]           lane_src [CDB_SIZE];
    logic [SW-1:0]           last_src;
    logic                    any_gnt;

    assign flush = rst | move_flush;

    // Per-source handshake, eligibility and candidate entry
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            nonempty[i] = (cnt[i] != '0);
            fu_ready[i] = (cnt[i] != FULL);
            push[i]     = fu_valid[i] & fu_ready[i];
`ifdef CDB_BYPASS_EN
            elig[i]     = nonempty[i] | push[i];
            src_ent[i]  = nonempty[i] ? mem[i][head[i]]
                                      : {fu_rob[i], fu_rd_v[i]};
`else
            elig[i]     = nonempty[i];
            src_ent[i]  = mem[i][head[i]];
`endif
            pop[i]      = gnt[i] & nonempty[i];
            wr[i]       = push[i] & ~(gnt[i] & ~nonempty[i]);
        end
    end

    // Round-robin scan from rr_ptr; first CDB_SIZE eligible sources fill lanes in order
    always_comb begin
        int n;
        int idx;
        n        = 0;
        idx      = 0;
        gnt      = '0;
        lane_vld = '0;
        last_src = '0;
        any_gnt  = 1'b0;
        for (int k = 0; k < CDB_SIZE; k++) lane_src[k] = '0;
        for (int j = 0; j < N_SRC; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (elig[idx] && n < CDB_SIZE) begin
                gnt[idx]    = 1'b1;
                lane_vld[n] = 1'b1;
                lane_src[n] = SW'(idx);
                last_src    = SW'(idx);
                any_gnt     = 1'b1;
                n           = n + 1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (wr[i])  tail[i] <= tail[i] + 1'b1;
                if (pop[i]) head[i] <= head[i] + 1'b1;
                case ({wr[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care once pointers are cleared
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (wr[i] && !flush) mem[i][tail[i]] <= {fu_rob[i], fu_rd_v[i]};
        end
    end

    // Registered CDB lanes; tag/value hold when a lane is idle
    always_ff @(posedge clk) begin
        if (flush) begin
            cdb_valid <= '0;
            cdb_rob   <= '0;
            cdb_rd_v  <= '0;
        end else begin
            for (int k = 0; k < CDB_SIZE; k++) begin
                cdb_valid[k] <= lane_vld[k];
                if (lane_vld[k]) begin
                    {cdb_rob[k], cdb_rd_v[k]} <= src_ent[lane_src[k]];
                end
            end
        end
    end

    // Resume the scan just past the last source that won a lane
    always_ff @(posedge clk) begin
        if (flush) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            if (last_src == SW'(N_SRC - 1)) rr_ptr <= '0;
            else                            rr_ptr <= last_src + 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus a saturation run with per-source scoreboard.
module tb_cdb_arbiter;

    logic                  clk;
    logic                  rst;
    logic                  move_flush;
    logic [3:0]            fu_valid;
    logic [3:0]            fu_ready;
    logic [3:0][3:0]       fu_rob;
    logic [3:0][31:0]      fu_rd_v;
    logic [2:0]            cdb_valid;
    logic [2:0][3:0]       cdb_rob;
    logic [2:0][31:0]      cdb_rd_v;

    cdb_arbiter #(
        .N_SRC(4), .CDB_SIZE(3), .ROB_DEPTH(4), .Q_DEPTH_BITS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .move_flush (move_flush),
        .fu_valid   (fu_valid),
        .fu_ready   (fu_ready),
        .fu_rob     (fu_rob),
        .fu_rd_v    (fu_rd_v),
        .cdb_valid  (cdb_valid),
        .cdb_rob    (cdb_rob),
        .cdb_rd_v   (cdb_rd_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            rst;
        logic            flush;
        logic [3:0]      vld;
        logic [3:0][3:0] rob;
        logic [3:0]      rdy;
        logic [2:0]      cv;
        logic [2:0][3:0] cr;
    } vec_t;

    vec_t             vt [15];
    int               errors = 0;
    int               total  = 0;
    logic [31:0]      q [4][$];
    int               sent [4];
    int               accepted = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dval(input logic [3:0] t);
        return 32'hDEADBEEA + {28'h0, t};
    endfunction

    function automatic int pending();
        int p = 0;
        for (int s = 0; s < 4; s++) p += q[s].size();
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Match every valid lane against the head of its source's queue
    task automatic score();
        for (int k = 0; k < 3; k++) begin
            if (cdb_valid[k]) begin
                int s;
                logic [31:0] e;
                s = int'(cdb_rd_v[k][23:16]);
                if (s < 4 && q[s].size() > 0) begin
                    e = q[s].pop_front();
                    chk("sb_data", 64'(cdb_rd_v[k]), 64'(e));
                    chk("sb_rob", 64'(cdb_rob[k]), 64'(e[3:0]));
                end else begin
                    total++;
                    errors++;
                    $display("FAIL sb_unexpected lane %0d: got %h expected none",
                             k, cdb_rd_v[k]);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        move_flush = 1'b0;
        fu_valid   = 4'hF;
        fu_rob     = 16'h4321;
        for (int s = 0; s < 4; s++) fu_rd_v[s] = dval(fu_rob[s]);

        // Reset held two cycles with all FUs valid
        cyc();
        chk("rst_valid0", 64'(cdb_valid), 64'h0);
        cyc();
        chk("rst_valid1", 64'(cdb_valid), 64'h0);
        chk("rst_rob", 64'(cdb_rob), 64'h0);
        rst      = 1'b0;
        fu_valid = 4'h0;
        chk("rst_ready", 64'(fu_ready), 64'hF);
        cyc();
        chk("post_rst_valid0", 64'(cdb_valid), 64'h0);
        cyc();
        chk("post_rst_valid1", 64'(cdb_valid), 64'h0);

        //          rst   fl    vld      rob       rdy   cv       cr
        vt[0]  = '{1'b0, 1'b0, 4'b0001, 16'h0005, 4'hF, 3'b000, 12'h000};
        vt[1]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b001, 12'h005};
        vt[2]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b000, 12'h000};
        vt[3]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b000, 12'h000};
        vt[4]  = '{1'b0, 1'b0, 4'b1111, 16'h4321, 4'hF, 3'b000, 12'h000};
        vt[5]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b111, 12'h321};
        vt[6]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b001, 12'h004};
        vt[7]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b000, 12'h000};
        vt[8]  = '{1'b0, 1'b0, 4'b1111, 16'h4321, 4'hF, 3'b000, 12'h000};
        vt[9]  = '{1'b0, 1'b0, 4'b1111, 16'h8765, 4'hF, 3'b111, 12'h321};
        vt[10] = '{1'b0, 1'b0, 4'b1111, 16'hCBA9, 4'hF, 3'b111, 12'h654};
        vt[11] = '{1'b0, 1'b0, 4'b1111, 16'h0FED, 4'hF, 3'b111, 12'h987};
        vt[12] = '{1'b0, 1'b1, 4'b1111, 16'h4321, 4'hF, 3'b000, 12'h000};
        vt[13] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b000, 12'h000};
        vt[14] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'hF, 3'b000, 12'h000};

        for (int i = 0; i < 15; i++) begin
            rst        = vt[i].rst;
            move_flush = vt[i].flush;
            fu_valid   = vt[i].vld;
            fu_rob     = vt[i].rob;
            for (int s = 0; s < 4; s++) fu_rd_v[s] = dval(vt[i].rob[s]);
            chk($sformatf("v%0d_ready", i), 64'(fu_ready), 64'(vt[i].rdy));
            cyc();
            chk($sformatf("v%0d_valid", i), 64'(cdb_valid), 64'(vt[i].cv));
            for (int k = 0; k < 3; k++) begin
                if (vt[i].cv[k]) begin
                    chk($sformatf("v%0d_rob%0d", i, k),
                        64'(cdb_rob[k]), 64'(vt[i].cr[k]));
                    chk($sformatf("v%0d_rdv%0d", i, k),
                        64'(cdb_rd_v[k]), 64'(dval(vt[i].cr[k])));
                end
            end
        end
        rst        = 1'b0;
        move_flush = 1'b0;

        // Saturation: all four FUs push every cycle, FIFOs fill to full
        for (int s = 0; s < 4; s++) sent[s] = 0;
        for (int c = 0; c < 12; c++) begin
            fu_valid = 4'hF;
            for (int s = 0; s < 4; s++) begin
                fu_rob[s]  = 4'(sent[s]);
                fu_rd_v[s] = {8'hA5, 8'(s), 16'(sent[s])};
            end
            if (c == 9)  chk("sat_ready_c9", 64'(fu_ready), 64'hF);
            if (c == 10) chk("sat_ready_c10_full3", 64'(fu_ready), 64'h7);
            if (c == 11) chk("sat_ready_c11_full2", 64'(fu_ready), 64'hB);
            for (int s = 0; s < 4; s++) begin
                if (fu_ready[s]) begin
                    q[s].push_back(fu_rd_v[s]);
                    sent[s]++;
                    accepted++;
                end
            end
            cyc();
            score();
        end

        // Drain with bounded cycle budget
        fu_valid = 4'h0;
        chk("drain_ready_start", 64'(fu_ready), 64'hD);
        for (int c = 0; c < 20 && pending() > 0; c++) begin
            cyc();
            score();
        end
        chk("drain_empty", 64'(pending()), 64'h0);
        chk("accepted", 64'(accepted), 64'd46);
        cyc();
        chk("idle_after_drain", 64'(cdb_valid), 64'h0);
        chk("idle_ready", 64'(fu_ready), 64'hF);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
